// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered decode/control stage with load-use hazard, EX hold, flush and illegal flagging
module decode_ctrl_stage #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [10:0]      optype,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic [XLEN-1:0]  data_1,
    input  logic [XLEN-1:0]  data_2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  immI,
    input  logic [XLEN-1:0]  immS,
    input  logic [XLEN-1:0]  immB,
    input  logic [XLEN-1:0]  immU,
    input  logic [XLEN-1:0]  immJ,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [4:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_jalr,
    output logic [XLEN-1:0]  ex_x,
    output logic [XLEN-1:0]  ex_y,
    output logic [XLEN-1:0]  ex_write_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rd,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] bubble_count
);
    localparam logic [4:0] SUB = 5'b00001;
    localparam logic [4:0] SRA = 5'b00111;
    function automatic logic [4:0] arith_op(input logic [2:0] f);
        case (f)
            3'b000:  return 5'b00000;
            3'b001:  return 5'b00101;
            3'b010:  return 5'b01000;
            3'b011:  return 5'b01001;
            3'b100:  return 5'b00010;
            3'b101:  return 5'b00110;
            3'b110:  return 5'b00011;
            default: return 5'b00100;
        endcase
    endfunction
    function automatic logic [4:0] branch_op(input logic [2:0] f);
        case (f)
            3'b000:  return 5'b01010;
            3'b001:  return 5'b01011;
            3'b100:  return 5'b01000;
            3'b101:  return 5'b01100;
            3'b110:  return 5'b01001;
            default: return 5'b01101;
        endcase
    endfunction
    logic [4:0]      d_alu_op, d_rd;
    logic            d_alu_src, d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg;
    logic            d_branch, d_jump, d_jalr, d_illegal;
    logic [XLEN-1:0] d_x, d_y, d_write_data, d_imm;
    logic            m_op, uses_rs1, uses_rs2, load_use, take;
    assign m_op = (ENABLE_M != 0) && funct7 == 7'b0000001;
    always_comb begin
        d_alu_op     = '0;
        d_alu_src    = 1'b0;
        d_reg_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_branch     = 1'b0;
        d_jump       = 1'b0;
        d_jalr       = 1'b0;
        d_illegal    = 1'b0;
        d_x          = data_1;
        d_y          = data_2;
        d_write_data = '0;
        d_imm        = '0;
        case (optype)
            11'h001: begin
                d_reg_write = 1'b1;
                d_alu_op    = m_op ? {2'b10, funct3} :
                              funct7 == 7'b0100000 ? (funct3 == 3'b000 ? SUB : SRA) : arith_op(funct3);
                d_illegal   = !(funct7 == 7'b0 || m_op ||
                                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            11'h002: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm       = immI;
                d_alu_op    = funct3 == 3'b101 && immI[10] ? SRA : arith_op(funct3);
                d_illegal   = (funct3 == 3'b001 && immI[11:5] != 7'b0) ||
                              (funct3 == 3'b101 && immI[11:5] != 7'b0 && immI[11:5] != 7'b0100000);
            end
            11'h004: begin
                d_reg_write  = 1'b1;
                d_alu_src    = 1'b1;
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
                d_imm        = immI;
            end
            11'h008: begin
                d_alu_src    = 1'b1;
                d_mem_write  = 1'b1;
                d_imm        = immS;
                d_write_data = data_2;
            end
            11'h010: begin
                d_branch  = 1'b1;
                d_imm     = immB;
                d_alu_op  = branch_op(funct3);
                d_illegal = funct3[2:1] == 2'b01;
            end
            11'h020, 11'h040: begin
                d_reg_write = 1'b1;
                d_jump      = 1'b1;
                d_jalr      = optype[6];
                d_x         = pc;
                d_y         = XLEN'(4);
                d_imm       = optype[6] ? immI : immJ;
            end
            11'h080, 11'h100: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_x         = optype[8] ? pc : '0;
                d_imm       = immU;
            end
            11'h200: ;
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) {d_alu_op, d_alu_src, d_reg_write, d_mem_read, d_mem_write,
                        d_mem_to_reg, d_branch, d_jump, d_jalr} = '0;
        d_rd = d_reg_write ? rd : '0;
    end
    assign uses_rs1 = |optype[4:0] | optype[6];
    assign uses_rs2 = optype[0] | optype[3] | optype[4];
    assign load_use = in_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == rs1 & uses_rs1) | (ex_rd == rs2 & uses_rs2));
    assign id_stall = ex_stall | (load_use & ~flush);
    assign take     = ~flush & in_valid & ~load_use;
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_jalr       <= 1'b0;
            ex_x          <= '0;
            ex_y          <= '0;
            ex_write_data <= '0;
            ex_imm        <= '0;
            ex_rd         <= '0;
            ex_illegal    <= 1'b0;
            bubble_count  <= '0;
        end else if (flush || !ex_stall) begin
            ex_valid      <= take;
            ex_alu_op     <= take ? d_alu_op : '0;
            ex_alu_src    <= take & d_alu_src;
            ex_reg_write  <= take & d_reg_write;
            ex_mem_read   <= take & d_mem_read;
            ex_mem_write  <= take & d_mem_write;
            ex_mem_to_reg <= take & d_mem_to_reg;
            ex_branch     <= take & d_branch;
            ex_jump       <= take & d_jump;
            ex_jalr       <= take & d_jalr;
            ex_rd         <= take ? d_rd : '0;
            ex_illegal    <= take & d_illegal;
            if (take) begin
                ex_x          <= d_x;
                ex_y          <= d_y;
                ex_write_data <= d_write_data;
                ex_imm        <= d_imm;
            end
            if (!flush && load_use && !(&bubble_count)) bubble_count <= bubble_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: scoreboard bench for decode_ctrl_stage (base instance plus M-enabled, narrow-counter instance)
module tb_decode_ctrl_stage;
    localparam int XLEN = 32;
    localparam logic [10:0] R = 11'h001, IA = 11'h002, LD = 11'h004, ST = 11'h008, BR = 11'h010;
    localparam logic [10:0] JL = 11'h020, JR = 11'h040, LU = 11'h080, AU = 11'h100, SY = 11'h200;
    localparam logic [7:0] F_SRC = 8'h80, F_RW = 8'h40, F_MR = 8'h20, F_MW = 8'h10;
    localparam logic [7:0] F_M2R = 8'h08, F_BR = 8'h04, F_J = 8'h02, F_JR = 8'h01;
    logic clk = 1'b0;
    logic rst, in_valid, ex_stall, flush;
    logic [10:0] optype;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] data_1, data_2, pc, immI, immS, immB, immU, immJ;
    logic id_stall, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic ex_branch, ex_jump, ex_jalr, ex_illegal;
    logic [4:0] ex_alu_op, ex_rd;
    logic [XLEN-1:0] ex_x, ex_y, ex_write_data, ex_imm;
    logic [15:0] bubble_count;
    logic m_id_stall, m_ex_valid, m_ex_alu_src, m_ex_reg_write, m_ex_mem_read, m_ex_mem_write;
    logic m_ex_mem_to_reg, m_ex_branch, m_ex_jump, m_ex_jalr, m_ex_illegal;
    logic [4:0] m_ex_alu_op, m_ex_rd;
    logic [XLEN-1:0] m_ex_x, m_ex_y, m_ex_write_data, m_ex_imm;
    logic [1:0] m_bubble_count;
    decode_ctrl_stage #(.XLEN(XLEN), .ENABLE_M(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .optype(optype), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .data_1(data_1), .data_2(data_2), .pc(pc),
        .immI(immI), .immS(immS), .immB(immB), .immU(immU), .immJ(immJ),
        .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_x(ex_x), .ex_y(ex_y),
        .ex_write_data(ex_write_data), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
        .bubble_count(bubble_count)
    );
    decode_ctrl_stage #(.XLEN(XLEN), .ENABLE_M(1), .CNT_W(2)) u_dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .optype(optype), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .data_1(data_1), .data_2(data_2), .pc(pc),
        .immI(immI), .immS(immS), .immB(immB), .immU(immU), .immJ(immJ),
        .ex_stall(ex_stall), .flush(flush), .id_stall(m_id_stall), .ex_valid(m_ex_valid),
        .ex_alu_op(m_ex_alu_op), .ex_alu_src(m_ex_alu_src), .ex_reg_write(m_ex_reg_write),
        .ex_mem_read(m_ex_mem_read), .ex_mem_write(m_ex_mem_write), .ex_mem_to_reg(m_ex_mem_to_reg),
        .ex_branch(m_ex_branch), .ex_jump(m_ex_jump), .ex_jalr(m_ex_jalr), .ex_x(m_ex_x), .ex_y(m_ex_y),
        .ex_write_data(m_ex_write_data), .ex_imm(m_ex_imm), .ex_rd(m_ex_rd), .ex_illegal(m_ex_illegal),
        .bubble_count(m_bubble_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic v;
        logic [4:0] op;
        logic [7:0] fl;
        logic [XLEN-1:0] x, y, wd, imm;
        logic [4:0] rd;
        logic ill;
        bit ops;
        int bc;
    } exp_t;
    exp_t q[$];
    exp_t last, e;
    int n_chk = 0, n_pass = 0, bc = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic exp_t mk(input logic v, input logic [4:0] op, input logic [7:0] fl,
                                input logic [XLEN-1:0] x, y, wd, imm, input logic [4:0] r,
                                input logic ill, input bit ops);
        exp_t t;
        t.v = v; t.op = op; t.fl = fl; t.x = x; t.y = y; t.wd = wd; t.imm = imm;
        t.rd = r; t.ill = ill; t.ops = ops; t.bc = bc;
        return t;
    endfunction
    function automatic exp_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic exp_t illegal();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endfunction
    task automatic issue(input exp_t t);
        q.push_back(t);
        last = t;
        @(negedge clk);
    endtask
    task automatic instr(input logic [10:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        in_valid = 1'b1; optype = o; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; rd = d;
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("valid", ex_valid, e.v);
            check("flags", {ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                            ex_branch, ex_jump, ex_jalr}, e.fl);
            check("rd", ex_rd, e.rd);
            check("illegal", ex_illegal, e.ill);
            check("bubble_count", bubble_count, 64'(e.bc));
            check("bubble_count_sat", m_bubble_count, 64'(e.bc > 3 ? 3 : e.bc));
            if (e.ops) begin
                check("alu_op", ex_alu_op, e.op);
                check("x", ex_x, e.x);
                check("y", ex_y, e.y);
                check("write_data", ex_write_data, e.wd);
                check("imm", ex_imm, e.imm);
            end
        end
    end
    initial begin
        rst = 1'b1; in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        instr(11'h0, 0, 0, 0, 0, 0); in_valid = 1'b0;
        data_1 = '0; data_2 = '0; pc = 32'h200;
        immI = 32'h8; immS = 32'h14; immB = 32'h20; immU = 32'h12345000; immJ = 32'h40;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        instr(R, 3'b000, 7'h20, 1, 2, 5); data_1 = 10; data_2 = 3;
        issue(mk(1, 5'b00001, F_RW, 10, 3, 0, 0, 5, 0, 1));
        instr(LD, 3'b010, 0, 1, 0, 7); data_1 = 100; data_2 = 0;
        issue(mk(1, 0, F_SRC | F_RW | F_MR | F_M2R, 100, 0, 0, 8, 7, 0, 1));
        instr(R, 3'b000, 0, 3, 7, 9); data_1 = 1; data_2 = 2;
        #1 check("load_use_stall", id_stall, 1);
        bc++;
        issue(bubble());
        #1 check("load_use_release", id_stall, 0);
        issue(mk(1, 0, F_RW, 1, 2, 0, 0, 9, 0, 1));
        instr(LD, 3'b010, 0, 1, 0, 0); data_1 = 100; data_2 = 0;
        issue(mk(1, 0, F_SRC | F_RW | F_MR | F_M2R, 100, 0, 0, 8, 0, 0, 1));
        instr(R, 3'b000, 0, 3, 0, 9); data_1 = 1; data_2 = 2;
        #1 check("load_x0_no_stall", id_stall, 0);
        issue(mk(1, 0, F_RW, 1, 2, 0, 0, 9, 0, 1));
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr(ST, 3'b010, 0, 5'(i), 5'(i + 1), 5'(i + 2)); data_1 = 32'(i * 7 + 1);
            #1 check("ex_stall_id_stall", id_stall, 1);
            issue(last);
        end
        flush = 1'b1;
        issue(bubble());
        flush = 1'b0; ex_stall = 1'b0;
        instr(ST, 3'b010, 0, 1, 2, 3); data_1 = 32'h40; data_2 = 32'hdead;
        issue(mk(1, 0, F_SRC | F_MW, 32'h40, 32'hdead, 32'hdead, 32'h14, 0, 0, 1));
        instr(LD, 3'b010, 0, 1, 0, 6); data_1 = 5; data_2 = 0;
        issue(mk(1, 0, F_SRC | F_RW | F_MR | F_M2R, 5, 0, 0, 8, 6, 0, 1));
        instr(R, 3'b000, 0, 6, 1, 9); flush = 1'b1;
        #1 check("flush_masks_load_use", id_stall, 0);
        issue(bubble());
        flush = 1'b0;
        instr(R, 3'b000, 7'h01, 1, 2, 4); data_1 = 6; data_2 = 7;
        issue(illegal());
        check("m_mul_op", m_ex_alu_op, 5'b10000);
        check("m_mul_reg_write", m_ex_reg_write, 1);
        check("m_mul_rd", m_ex_rd, 4);
        check("m_mul_illegal", m_ex_illegal, 0);
        instr(R, 3'b011, 7'h01, 1, 2, 4);
        issue(illegal());
        check("m_mulhu_op", m_ex_alu_op, 5'b10011);
        instr(R, 3'b001, 7'h20, 1, 2, 4);
        issue(illegal());
        check("m_bad_funct7_illegal", m_ex_illegal, 1);
        instr(R, 3'b101, 7'h20, 1, 2, 4); data_1 = 32'hf0;
        issue(mk(1, 5'b00111, F_RW, 32'hf0, 7, 0, 0, 4, 0, 1));
        instr(R, 3'b011, 7'h00, 1, 2, 4);
        issue(mk(1, 5'b01001, F_RW, 32'hf0, 7, 0, 0, 4, 0, 1));
        instr(JR, 3'b000, 0, 2, 0, 1); pc = 32'h100;
        issue(mk(1, 0, F_RW | F_J | F_JR, 32'h100, 4, 0, 8, 1, 0, 1));
        instr(JL, 3'b000, 0, 0, 0, 3);
        issue(mk(1, 0, F_RW | F_J, 32'h100, 4, 0, 32'h40, 3, 0, 1));
        instr(BR, 3'b110, 0, 1, 2, 5); data_1 = 1; data_2 = 2;
        issue(mk(1, 5'b01001, F_BR, 1, 2, 0, 32'h20, 0, 0, 1));
        instr(BR, 3'b101, 0, 1, 2, 5);
        issue(mk(1, 5'b01100, F_BR, 1, 2, 0, 32'h20, 0, 0, 1));
        instr(BR, 3'b010, 0, 1, 2, 5);
        issue(illegal());
        immI = 32'h403; instr(IA, 3'b101, 0, 1, 0, 8); data_1 = 32'hfffffff0;
        issue(mk(1, 5'b00111, F_SRC | F_RW, 32'hfffffff0, 2, 0, 32'h403, 8, 0, 1));
        immI = 32'h401; instr(IA, 3'b001, 0, 1, 0, 8);
        issue(illegal());
        immI = 32'h8; instr(IA, 3'b100, 0, 1, 0, 8);
        issue(mk(1, 5'b00010, F_SRC | F_RW, 32'hfffffff0, 2, 0, 8, 8, 0, 1));
        instr(LU, 3'b000, 0, 0, 0, 10); data_1 = 55;
        issue(mk(1, 0, F_SRC | F_RW, 0, 2, 0, 32'h12345000, 10, 0, 1));
        instr(AU, 3'b000, 0, 0, 0, 10);
        issue(mk(1, 0, F_SRC | F_RW, 32'h100, 2, 0, 32'h12345000, 10, 0, 1));
        instr(SY, 3'b000, 0, 0, 0, 11);
        issue(mk(1, 0, 0, 55, 2, 0, 0, 0, 0, 1));
        instr(11'h000, 3'b000, 0, 0, 0, 11);
        issue(illegal());
        instr(R | LD, 3'b000, 0, 0, 0, 11);
        issue(illegal());
        instr(11'h400, 3'b000, 0, 0, 0, 11);
        issue(illegal());
        in_valid = 1'b0;
        issue(bubble());
        for (int i = 0; i < 3; i++) begin
            instr(LD, 3'b010, 0, 1, 0, 7); data_1 = 32'(i); data_2 = 0;
            issue(mk(1, 0, F_SRC | F_RW | F_MR | F_M2R, 32'(i), 0, 0, 8, 7, 0, 1));
            instr(ST, 3'b010, 0, 2, 7, 0); data_1 = 9; data_2 = 11;
            bc++;
            issue(bubble());
            issue(mk(1, 0, F_SRC | F_MW, 9, 11, 11, 32'h14, 0, 0, 1));
        end
        in_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
